// File: rtl/imem_arb.sv
// Code-memory arbiter: fetch reads vs loader writes, same-address hazards, fetch anti-starvation.
// Optional IMEM_BOOT_HOLD_EN: hold fetches in BOOT after reset until ld_done.
module imem_arb #(
  parameter int AW         = 30,
  parameter int STARVE_MAX = 3
) (
  input  logic          sysclk,
  input  logic          sys_rst,
  input  logic          icache_ack,
  input  logic [AW-1:0] icache_addr,
  output logic          icache_vld,
  output logic [31:0]   icache_data,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          ld_ack,
  input  logic          ld_done,
  output logic          mem_cena,
  output logic [AW-1:0] mem_aa,
  input  logic [31:0]   mem_qa,
  output logic          mem_cenb,
  output logic [AW-1:0] mem_ab,
  output logic [31:0]   mem_db
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_icache_vld;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_aa;

  logic w_run;
  logic w_hazard;
  logic w_starve;
  logic w_rd;
  logic w_wr;

  assign w_run    = (r_state == RUN);
  // A hazard only exists when a read could actually issue this cycle.
  assign w_hazard = w_run & icache_ack & ld_req & (ld_addr == icache_addr);
  assign w_starve = (r_cnt == CW'(STARVE_MAX));
  assign w_rd     = ~sys_rst & w_run & icache_ack & (~w_hazard | w_starve);
  assign w_wr     = ~sys_rst & ld_req & ~(w_hazard & w_starve);

  assign mem_cena    = ~w_rd;
  assign mem_aa      = w_rd ? icache_addr : r_aa;
  assign mem_cenb    = ~w_wr;
  assign mem_ab      = ld_addr;
  assign mem_db      = ld_data;
  assign ld_ack      = w_wr;
  assign icache_vld  = r_icache_vld;
  assign icache_data = mem_qa;

`ifndef IMEM_BOOT_HOLD_EN
  logic w_unused_ld_done;
  assign w_unused_ld_done = ld_done;
`endif

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
`ifdef IMEM_BOOT_HOLD_EN
      r_state <= BOOT;
`else
      r_state <= RUN;
`endif
      r_icache_vld <= 1'b0;
      r_cnt        <= '0;
      r_aa         <= '0;
    end else begin
`ifdef IMEM_BOOT_HOLD_EN
      if (r_state == BOOT && ld_done) begin
        r_state <= RUN;
      end
`endif
      r_icache_vld <= w_rd;
      if (w_rd) begin
        r_aa <= icache_addr;
      end
      if (!icache_ack || w_rd) begin
        r_cnt <= '0;
      end else if (w_hazard && !w_starve) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_arb.sv
// Directed table-driven bench for imem_arb with a small synchronous code-memory model.
module tb_imem_arb;

  localparam int AW = 30;

  logic          sysclk = 1'b0;
  logic          sys_rst;
  logic          icache_ack;
  logic [AW-1:0] icache_addr;
  logic          icache_vld;
  logic [31:0]   icache_data;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic          ld_ack;
  logic          ld_done;
  logic          mem_cena;
  logic [AW-1:0] mem_aa;
  logic [31:0]   mem_qa;
  logic          mem_cenb;
  logic [AW-1:0] mem_ab;
  logic [31:0]   mem_db;

  int total = 0;
  int bad   = 0;

  always #5 sysclk = ~sysclk;

  imem_arb #(.AW(AW), .STARVE_MAX(3)) dut (
    .sysclk(sysclk), .sys_rst(sys_rst),
    .icache_ack(icache_ack), .icache_addr(icache_addr),
    .icache_vld(icache_vld), .icache_data(icache_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ack(ld_ack), .ld_done(ld_done),
    .mem_cena(mem_cena), .mem_aa(mem_aa), .mem_qa(mem_qa),
    .mem_cenb(mem_cenb), .mem_ab(mem_ab), .mem_db(mem_db)
  );

  // Code memory: one-cycle read latency, contents re-seeded on reset.
  logic [31:0] mem [0:255];
  always @(posedge sysclk) begin
    if (sys_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 + 32'(i);
      mem_qa <= '0;
    end else begin
      if (!mem_cenb) mem[mem_ab[7:0]] <= mem_db;
      if (!mem_cena) mem_qa <= mem[mem_aa[7:0]];
    end
  end

  typedef struct {
    logic          ia;
    logic [AW-1:0] iaddr;
    logic          lr;
    logic [AW-1:0] laddr;
    logic [31:0]   ldat;
    logic          e_cena;
    logic [AW-1:0] e_aa;
    logic          e_cenb;
    logic          e_ack;
    logic          e_vld;
    logic          chk_dat;
    logic [31:0]   e_dat;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic ia, input logic [AW-1:0] iaddr,
                              input logic lr, input logic [AW-1:0] laddr, input logic [31:0] ldat,
                              input logic e_cena, input logic [AW-1:0] e_aa, input logic e_cenb,
                              input logic e_ack, input logic e_vld, input logic chk_dat,
                              input logic [31:0] e_dat);
    vec_t v;
    v.ia = ia; v.iaddr = iaddr; v.lr = lr; v.laddr = laddr; v.ldat = ldat;
    v.e_cena = e_cena; v.e_aa = e_aa; v.e_cenb = e_cenb; v.e_ack = e_ack;
    v.e_vld = e_vld; v.chk_dat = chk_dat; v.e_dat = e_dat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ia, input logic [AW-1:0] ia_addr,
                       input logic lr, input logic [AW-1:0] la, input logic [31:0] ld);
    icache_ack = ia; icache_addr = ia_addr; ld_req = lr; ld_addr = la; ld_data = ld;
  endtask

  // Drive just after the edge, sample at the falling edge.
  task automatic next_cycle();
    @(posedge sysclk);
    #1;
  endtask

  initial begin
    sys_rst = 1'b1; ld_done = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0);

    // Vectors: {ia, iaddr, lr, laddr, ldat | cena, aa, cenb, ack, vld, chk_dat, dat}
    vecs[0]  = mk(0, 'h00, 0, 'h00, 32'h0,        1, 'h00, 1, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 'h10, 0, 'h00, 32'h0,        0, 'h10, 1, 0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 'h00, 0, 'h00, 32'h0,        1, 'h10, 1, 0, 1, 1, 32'hA500_0010);
    vecs[3]  = mk(1, 'h04, 1, 'h08, 32'hDEADBEEF, 0, 'h04, 0, 1, 0, 0, 32'h0);
    vecs[4]  = mk(1, 'h08, 0, 'h00, 32'h0,        0, 'h08, 1, 0, 1, 1, 32'hA500_0004);
    vecs[5]  = mk(0, 'h00, 0, 'h00, 32'h0,        1, 'h08, 1, 0, 1, 1, 32'hDEADBEEF);
    vecs[6]  = mk(1, 'h31, 1, 'h30, 32'hCAFE0030, 0, 'h31, 0, 1, 0, 0, 32'h0);
    vecs[7]  = mk(0, 'h00, 0, 'h00, 32'h0,        1, 'h31, 1, 0, 1, 1, 32'hA500_0031);
    // Hazard at 0x20: three stalls, then the read wins and the write is held.
    vecs[8]  = mk(1, 'h20, 1, 'h20, 32'h12345678, 1, 'h31, 0, 1, 0, 0, 32'h0);
    vecs[9]  = mk(1, 'h20, 1, 'h20, 32'h12345678, 1, 'h31, 0, 1, 0, 0, 32'h0);
    vecs[10] = mk(1, 'h20, 1, 'h20, 32'h12345678, 1, 'h31, 0, 1, 0, 0, 32'h0);
    vecs[11] = mk(1, 'h20, 1, 'h20, 32'h12345678, 0, 'h20, 1, 0, 0, 0, 32'h0);
    vecs[12] = mk(0, 'h00, 1, 'h20, 32'h12345678, 1, 'h20, 0, 1, 1, 1, 32'h12345678);
    vecs[13] = mk(0, 'h00, 0, 'h00, 32'h0,        1, 'h20, 1, 0, 0, 0, 32'h0);
    // One stall, then icache_ack drops and must clear the counter.
    vecs[14] = mk(1, 'h40, 1, 'h40, 32'h11110040, 1, 'h20, 0, 1, 0, 0, 32'h0);
    vecs[15] = mk(0, 'h00, 1, 'h40, 32'h22220040, 1, 'h20, 0, 1, 0, 0, 32'h0);
    vecs[16] = mk(1, 'h40, 1, 'h40, 32'h33330040, 1, 'h20, 0, 1, 0, 0, 32'h0);
    vecs[17] = mk(1, 'h40, 1, 'h40, 32'h33330040, 1, 'h20, 0, 1, 0, 0, 32'h0);
    vecs[18] = mk(1, 'h40, 1, 'h40, 32'h33330040, 1, 'h20, 0, 1, 0, 0, 32'h0);
    vecs[19] = mk(1, 'h40, 1, 'h40, 32'h33330040, 0, 'h40, 1, 0, 0, 0, 32'h0);
    vecs[20] = mk(0, 'h00, 1, 'h40, 32'h33330040, 1, 'h40, 0, 1, 1, 1, 32'h33330040);
    vecs[21] = mk(0, 'h00, 0, 'h00, 32'h0,        1, 'h40, 1, 0, 0, 0, 32'h0);

    // Reset state
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk("rst icache_vld", 32'(icache_vld), 32'd0);
    chk("rst ld_ack",     32'(ld_ack),     32'd0);
    chk("rst mem_cena",   32'(mem_cena),   32'd1);
    chk("rst mem_cenb",   32'(mem_cenb),   32'd1);
    next_cycle();
    sys_rst = 1'b0;

`ifdef IMEM_BOOT_HOLD_EN
    // BOOT: fetch held off, loader writes still accepted, ld_done releases fetch.
    drive(1'b1, 'h10, 1'b1, 'h50, 32'h0B0075EE);
    @(negedge sysclk);
    chk("boot cena", 32'(mem_cena), 32'd1);
    chk("boot ack",  32'(ld_ack),   32'd1);
    next_cycle();
    drive(1'b1, 'h10, 1'b0, '0, '0);
    ld_done = 1'b1;
    @(negedge sysclk);
    chk("boot done cena", 32'(mem_cena),   32'd1);
    chk("boot done vld",  32'(icache_vld), 32'd0);
    next_cycle();
    ld_done = 1'b0;
    @(negedge sysclk);
    chk("boot run cena", 32'(mem_cena),   32'd0);
    chk("boot run vld",  32'(icache_vld), 32'd0);
    next_cycle();
    drive(1'b0, '0, 1'b0, '0, '0);
    @(negedge sysclk);
    chk("boot run vld1", 32'(icache_vld),  32'd1);
    chk("boot run dat",  icache_data,      32'hA500_0010);
    next_cycle();
    @(negedge sysclk);
    next_cycle();
`endif

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ia, vecs[i].iaddr, vecs[i].lr, vecs[i].laddr, vecs[i].ldat);
      @(negedge sysclk);
      chk($sformatf("v%0d mem_cena", i), 32'(mem_cena), 32'(vecs[i].e_cena));
      chk($sformatf("v%0d mem_aa", i),   32'(mem_aa),   32'(vecs[i].e_aa));
      chk($sformatf("v%0d mem_cenb", i), 32'(mem_cenb), 32'(vecs[i].e_cenb));
      chk($sformatf("v%0d ld_ack", i),   32'(ld_ack),   32'(vecs[i].e_ack));
      chk($sformatf("v%0d icache_vld", i), 32'(icache_vld), 32'(vecs[i].e_vld));
      if (!vecs[i].e_cenb) begin
        chk($sformatf("v%0d mem_ab", i), 32'(mem_ab), 32'(vecs[i].laddr));
        chk($sformatf("v%0d mem_db", i), mem_db,      vecs[i].ldat);
      end
      if (vecs[i].chk_dat) chk($sformatf("v%0d icache_data", i), icache_data, vecs[i].e_dat);
      next_cycle();
    end

    // Reset in the middle of a hazard stall, then a fresh stall sequence.
    drive(1'b1, 'h50, 1'b1, 'h50, 32'h55550050);
    repeat (2) begin
      @(negedge sysclk);
      chk("pre-rst stall cena", 32'(mem_cena), 32'd1);
      next_cycle();
    end
    sys_rst = 1'b1;
    @(negedge sysclk);
    chk("mid-rst cena", 32'(mem_cena), 32'd1);
    chk("mid-rst cenb", 32'(mem_cenb), 32'd1);
    chk("mid-rst ack",  32'(ld_ack),   32'd0);
    next_cycle();
    sys_rst = 1'b0;
    @(negedge sysclk);
    chk("post-rst vld", 32'(icache_vld), 32'd0);
`ifndef IMEM_BOOT_HOLD_EN
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge sysclk);
      chk($sformatf("post-rst c%0d cena", c), 32'(mem_cena), (c == 3) ? 32'd0 : 32'd1);
      chk($sformatf("post-rst c%0d ack", c),  32'(ld_ack),   (c == 3) ? 32'd0 : 32'd1);
      next_cycle();
    end
    drive(1'b0, '0, 1'b0, '0, '0);
    @(negedge sysclk);
    chk("post-rst read vld", 32'(icache_vld), 32'd1);
    chk("post-rst read dat", icache_data,     32'h55550050);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter AW, default 30, word-address width of the code memory.
REQ-002 SHALL have parameter STARVE_MAX, default 3, the number of consecutive fetch stalls tolerated before fetch is forced to win.
REQ-003 sysclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 sys_rst  in  1  synchronous reset, active-high.
REQ-005 icache_ack  in  1  fetch request; the requester holds it high with a stable icache_addr until served.
REQ-006 icache_addr  in  AW  fetch word address.
REQ-007 icache_vld  out  1  fetch data valid and fetch request consumed.
REQ-008 icache_data  out  32  fetch data (mem_qa passed through).
REQ-009 ld_req  in  1  loader write request; ld_addr and ld_data are held stable until ld_ack.
REQ-010 ld_addr  in  AW  loader word address.
REQ-011 ld_data  in  32  loader write data.
REQ-012 ld_ack  out  1  one-cycle pulse: write performed.
REQ-013 ld_done  in  1  one-cycle pulse: program load complete.
REQ-014 mem_cena  out  1  read-port enable to the code memory, active-low.
REQ-015 mem_aa  out  AW  read-port address.
REQ-016 mem_qa  in  32  read-port data, valid one cycle after a read is issued.
REQ-017 mem_cenb  out  1  write-port enable, active-low.
REQ-018 mem_ab  out  AW  write-port address.
REQ-019 mem_db  out  32  write-port data.

Function
REQ-020 SHALL be an FSM with two states: BOOT, in which fetches are never issued, and RUN.
REQ-021 Write issue, in any state: mem_cenb=0, mem_ab=ld_addr and mem_db=ld_data in every cycle where ld_req=1 and the write is not blocked by REQ-024.
REQ-022 ld_ack SHALL be high in the same cycle as the write; the loader drops or advances ld_req on the next cycle.
REQ-023 Read issue in RUN: mem_cena=0 and mem_aa=icache_addr when icache_ack=1 and the read is not blocked.
REQ-024 Hazard definition: ld_req=1 and ld_addr==icache_addr with icache_ack=1 in the same cycle.
  - Default: the write wins and the read is stalled.
  - Exception: if the stall counter equals STARVE_MAX, the read wins, the write is held (ld_ack=0) and the counter clears.
REQ-025 Without a hazard, a read and a write to different addresses SHALL issue in the same cycle.
REQ-026 Stall counter behaviour:
  - increments on each hazard-stalled read, saturating at STARVE_MAX;
  - clears on any issued read;
  - clears when icache_ack=0.
REQ-027 icache_vld SHALL be a register set in cycle t+1 only if a read issued in cycle t; one-cycle read latency, no back-to-back bubble.
REQ-028 icache_data SHALL equal mem_qa combinationally.
REQ-029 mem_aa SHALL hold the last issued address when no read issues, so that mem_qa stays stable.

Reset
REQ-030 While sys_rst=1 the block SHALL drive: icache_vld=0, ld_ack=0, mem_cena=1, mem_cenb=1, stall counter=0, state=BOOT if IMEM_BOOT_HOLD_EN is defined else RUN.
REQ-031 A reset arriving mid-stall SHALL discard the pending fetch and write.
REQ-032 The requesters SHALL re-present any request discarded by reset.

Configuration
REQ-033 Macro IMEM_BOOT_HOLD_EN:
  - Defined: reset enters BOOT; writes are accepted in BOOT; ld_done moves BOOT->RUN at the next edge; ld_done in RUN is ignored.
  - Undefined: reset enters RUN, BOOT is unreachable and ld_done is ignored.

Verification
REQ-034 Reset, then icache_ack=1 with icache_addr=0x10 in RUN -> mem_cena=0 and mem_aa=0x10 in that cycle; icache_vld=1 next cycle with icache_data=mem[0x10].
REQ-035 Read at 0x4 and write 0xDEADBEEF at 0x8 in the same cycle -> both issue, ld_ack=1, icache_vld=1 next cycle.
REQ-036 Continuous write stream at 0x20 while fetching 0x20, STARVE_MAX=3 -> 3 stalled cycles, then the read issues on the 4th with ld_ack=0 that cycle, and the write completes on the following cycle.
REQ-037 IMEM_BOOT_HOLD_EN defined, icache_ack=1 from reset -> no read issued and icache_vld=0 until one cycle after the ld_done pulse.
REQ-038 sys_rst asserted during a hazard stall -> next cycle icache_vld=0, ld_ack=0, counter=0.
